// File: rtl/message_schedule_pkg.sv
// Shared SHA-256 message-schedule types, sizing constants and the small-sigma
// mixing functions used to expand a 16-word block into 64 round words.
package message_schedule_pkg;

    localparam int SCHED_ROUNDS = 64;
    localparam int BLOCK_WORDS  = 16;

    typedef logic [31:0] word_t;
    typedef word_t [BLOCK_WORDS-1:0] block_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t lower_sigma_zero(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t lower_sigma_one(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/message_schedule_word_calc.sv
// Combinational expansion of the next schedule word from the current window.
module schedule_word_calc
    import message_schedule_pkg::*;
(
    input  word_t win_0,
    input  word_t win_1,
    input  word_t win_9,
    input  word_t win_14,
    output word_t new_word
);

    // Sum wraps modulo 2^32; carries out of bit 31 are intentionally dropped.
    assign new_word = lower_sigma_one(win_14) + win_9 + lower_sigma_zero(win_1) + win_0;

endmodule

// File: rtl/message_schedule.sv
// Streams the 64 SHA-256 schedule words of one accepted block with valid/ready
// handshaking; the head of a sliding 16-word window is the word on offer.
module message_schedule
    import message_schedule_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_index,
    output logic         w_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic        blk_ready_n, w_valid_n, w_last_n;
    logic [5:0]  w_index_n;
    logic        accept, xfer;
    word_t       win [BLOCK_WORDS];
    word_t       new_word;
    block_t      blk_words;

    assign blk_words = blk_data;
    assign accept    = (state == IDLE) && blk_valid && blk_ready;
    assign xfer      = (state == RUN) && w_valid && w_ready;

    schedule_word_calc u_calc (
        .win_0    (win[0]),
        .win_1    (win[1]),
        .win_9    (win[9]),
        .win_14   (win[14]),
        .new_word (new_word)
    );

    always_comb begin
        state_n     = state;
        blk_ready_n = blk_ready;
        w_valid_n   = w_valid;
        w_index_n   = w_index;
        w_last_n    = w_last;
        case (state)
            IDLE: begin
                blk_ready_n = 1'b1;
                if (accept) begin
                    state_n     = RUN;
                    blk_ready_n = 1'b0;
                    w_valid_n   = 1'b1;
                    w_index_n   = 6'd0;
                    w_last_n    = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    w_index_n = w_index + 6'd1;
                    w_last_n  = (w_index == 6'(SCHED_ROUNDS - 2));
                    // Final round handed off: reopen for the next block.
                    if (w_last) begin
                        state_n     = IDLE;
                        w_valid_n   = 1'b0;
                        blk_ready_n = 1'b1;
                        w_last_n    = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            blk_ready <= 1'b0;
            w_valid   <= 1'b0;
            w_index   <= 6'd0;
            w_last    <= 1'b0;
        end else begin
            state     <= state_n;
            blk_ready <= blk_ready_n;
            w_valid   <= w_valid_n;
            w_index   <= w_index_n;
            w_last    <= w_last_n;
        end
    end

    // The output word is registered separately so it can be cleared by reset
    // while the window itself needs no reset (it is reloaded on every accept).
    always_ff @(posedge clk) begin
        if (reset) begin
            w_data <= '0;
        end else if (accept) begin
            w_data <= blk_words[BLOCK_WORDS-1];
        end else if (xfer) begin
            w_data <= win[1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win[i] <= blk_words[BLOCK_WORDS-1-i];
            end
        end else if (xfer) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[BLOCK_WORDS-1] <= new_word;
        end
    end

endmodule

// File: tb/tb_message_schedule.sv
// Directed and randomized bench for message_schedule against an array-based
// model of the SHA-256 schedule recurrence.
module tb_message_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];

    always #5 clk = ~clk;

    message_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .w_last    (w_last)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] d);
        for (int i = 0; i < 16; i++) exp_w[i] = d[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [511:0] d);
        int n;
        n = 0;
        while (blk_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("blk_ready_wait", blk_ready, 1);
        blk_data  = d;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        chk("first_valid", w_valid, 1);
        chk("first_index", w_index, 0);
    endtask

    task automatic stream(input int from_t, input int to_t, input int stall_at, input int stall_len);
        for (int t = from_t; t <= to_t; t++) begin
            chk("w_valid", w_valid, 1);
            chk("w_data", w_data, exp_w[t]);
            chk("w_index", w_index, t);
            chk("w_last", w_last, (t == 63));
            chk("blk_ready_run", blk_ready, 0);
            obs_w[t] = w_data;
            if (t == stall_at) begin
                w_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    step();
                    chk("stall_valid", w_valid, 1);
                    chk("stall_data", w_data, exp_w[t]);
                    chk("stall_index", w_index, t);
                end
            end
            w_ready = 1'b1;
            step();
        end
        if (to_t == 63) begin
            chk("done_valid", w_valid, 0);
            chk("done_ready", blk_ready, 1);
        end
    endtask

    initial begin
        logic [511:0] blk_a, blk_b;
        int st_at, st_len;

        reset     = 1'b1;
        blk_valid = 1'b0;
        w_ready   = 1'b1;
        blk_data  = '0;
        step();
        step();
        chk("rst_blk_ready", blk_ready, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_index", w_index, 0);
        chk("rst_w_last", w_last, 0);
        reset = 1'b0;
        step();
        chk("ready_after_reset", blk_ready, 1);
        chk("idle_w_valid", w_valid, 0);

        // "abc" padded block
        blk_a = {32'h61626380, {14{32'h0}}, 32'h00000018};
        build_model(blk_a);
        start_block(blk_a);
        stream(0, 63, -1, 0);
        chk("abc_w0", obs_w[0], 32'h61626380);
        chk("abc_w15", obs_w[15], 32'h00000018);
        chk("abc_w16", obs_w[16], 32'h61626380);
        chk("abc_w17", obs_w[17], 32'h000F0000);

        // All-zero block
        build_model('0);
        start_block('0);
        stream(0, 63, -1, 0);
        chk("zero_w63", obs_w[63], 32'h0);

        // Stall of 5 cycles at t=20
        blk_a = rnd_blk();
        build_model(blk_a);
        start_block(blk_a);
        stream(0, 63, 20, 5);

        // A competing block offered during RUN must be ignored
        blk_a = rnd_blk();
        blk_b = rnd_blk();
        build_model(blk_a);
        start_block(blk_a);
        blk_data  = blk_b;
        blk_valid = 1'b1;
        stream(0, 59, -1, 0);
        blk_valid = 1'b0;
        stream(60, 63, -1, 0);

        // Reset mid-block at t=30, asserted together with blk_valid and w_ready
        blk_a = rnd_blk();
        build_model(blk_a);
        start_block(blk_a);
        stream(0, 29, -1, 0);
        chk("pre_abort_index", w_index, 30);
        reset     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = rnd_blk();
        step();
        chk("abort_w_valid", w_valid, 0);
        chk("abort_w_index", w_index, 0);
        chk("abort_blk_ready", blk_ready, 0);
        chk("abort_w_last", w_last, 0);
        reset     = 1'b0;
        blk_valid = 1'b0;
        step();
        chk("abort_ready_rise", blk_ready, 1);
        chk("abort_idle_valid", w_valid, 0);
        blk_a = rnd_blk();
        build_model(blk_a);
        start_block(blk_a);
        stream(0, 63, -1, 0);

        // blk_valid held high across two back-to-back blocks
        blk_a = rnd_blk();
        blk_b = rnd_blk();
        build_model(blk_a);
        blk_data  = blk_a;
        blk_valid = 1'b1;
        step();
        chk("chain_first_valid", w_valid, 1);
        blk_data = blk_b;
        stream(0, 63, -1, 0);
        step();
        chk("chain_second_valid", w_valid, 1);
        chk("chain_second_index", w_index, 0);
        blk_valid = 1'b0;
        build_model(blk_b);
        stream(0, 63, -1, 0);

        // Random block with a random stall position and length
        blk_a  = rnd_blk();
        st_at  = int'($urandom_range(0, 63));
        st_len = int'($urandom_range(1, 4));
        build_model(blk_a);
        start_block(blk_a);
        stream(0, 63, st_at, st_len);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
